// File: rtl/line_window_ctrl_if.sv
// line_window_ctrl_if: pixel stream in, 3x3 window stream out, retire interrupt
interface line_window_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        o_ready;
    logic        i_out_ready;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
    modport master (
        output i_pixel_data, i_pixel_data_valid, i_out_ready,
        input  o_ready, o_pixel_data, o_pixel_data_valid, o_intr
    );
    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_out_ready,
        output o_ready, o_pixel_data, o_pixel_data_valid, o_intr
    );
endinterface

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: four round-robin line buffers feeding 3x3 windows to the convolution filter
module line_window_ctrl #(
    parameter int IMG_WIDTH = 512
) (
    input  logic              i_clk,
    input  logic              i_rst,
    line_window_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    typedef enum logic [1:0] {IDLE, READ, RETIRE} state_t;
    state_t          state_q;
    logic [7:0]      mem_q [4][IMG_WIDTH];
    logic [1:0]      wr_sel_q, rd_sel_q;
    logic [CW-1:0]   wr_col_q, rd_col_q;
    logic [2:0]      full_lines_q, full_lines_d;
    logic [71:0]     win, data_q;
    logic            valid_q, intr_q;
    logic            accept, line_done, retire;
    logic [1:0]      row_sel [3];
    logic [CW-1:0]   col_sel [3];

    assign bus.o_ready            = full_lines_q < 3'd4;
    assign bus.o_pixel_data       = data_q;
    assign bus.o_pixel_data_valid = valid_q;
    assign bus.o_intr             = intr_q;
    assign accept       = bus.i_pixel_data_valid && bus.o_ready;
    assign line_done    = accept && wr_col_q == CW'(IMG_WIDTH - 1);
    assign retire       = state_q == RETIRE;
    assign full_lines_d = full_lines_q + 3'(line_done) - 3'(retire);

    // Row 0 of the window is always the oldest line, whatever its physical buffer
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            row_sel[i] = rd_sel_q + 2'(i);
            col_sel[i] = rd_col_q + CW'(i);
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[(r*3+c)*8 +: 8] = mem_q[row_sel[r]][col_sel[c]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) mem_q[wr_sel_q][wr_col_q] <= bus.i_pixel_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wr_sel_q     <= '0;
            wr_col_q     <= '0;
            rd_sel_q     <= '0;
            rd_col_q     <= '0;
            full_lines_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            full_lines_q <= full_lines_d;
            if (accept) begin
                wr_col_q <= line_done ? '0 : wr_col_q + CW'(1);
                wr_sel_q <= line_done ? wr_sel_q + 2'd1 : wr_sel_q;
            end
            valid_q <= 1'b0;
            intr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    rd_col_q <= '0;
                    if (full_lines_q >= 3'd3) state_q <= READ;
                end
                READ: begin
                    if (bus.i_out_ready) begin
                        data_q  <= win;
                        valid_q <= 1'b1;
                        if (rd_col_q == CW'(IMG_WIDTH - 3)) state_q <= RETIRE;
                        else rd_col_q <= rd_col_q + CW'(1);
                    end
                end
                RETIRE: begin
                    rd_sel_q <= rd_sel_q + 2'd1;
                    intr_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
